// File: rtl/mmio_bridge.sv
// mmio_bridge: routes tagged CPU data accesses to device channels, with timeout, sticky bus error and a trace FIFO
module mmio_bridge #(
    parameter int ADDR_W = 30,
    parameter int NUM_DEV = 4,
    parameter logic [4*NUM_DEV-1:0] DEV_BASE = {4'hf, 4'he, 4'hd, 4'hc},
    parameter int TIMEOUT = 255,
    parameter int TRACE_DEPTH = 64,
    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1,
    localparam int TW = 2 + IDX_W + ADDR_W + 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_read_in,
    input  logic                  dmem_write_in,
    input  logic [ADDR_W-1:0]     dmem_addr,
    input  logic [31:0]           data_from_reg,
    input  logic [3:0]            dmem_byte_w_en,
    input  logic                  ext_stall,
    output logic                  mem_stall,
    output logic [31:0]           dmem_data_out,
    output logic                  mmio_hit,
    output logic                  bus_err,
    output logic [NUM_DEV-1:0]    dev_req,
    output logic                  dev_we,
    output logic [ADDR_W-1:0]     dev_addr,
    output logic [31:0]           dev_wdata,
    output logic [3:0]            dev_be,
    input  logic [NUM_DEV-1:0]    dev_ack,
    input  logic [NUM_DEV*32-1:0] dev_rdata,
    input  logic                  trace_rd_en,
    output logic [TW-1:0]         trace_data,
    output logic                  trace_empty,
    output logic                  trace_full,
    output logic [7:0]            trace_ovf
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(TRACE_DEPTH) + 1;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       rdata_q, wdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q, tag;
    logic              we_q, bus_err_q, hit_any, ack, tmo, push, do_rd, do_wr;
    logic [IDX_W-1:0]  idx_q, hit_idx;
    logic [TW-1:0]     trace_d;
    logic [TW-1:0]     mem_q [TRACE_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [7:0]        ovf_q;

    assign tag = dmem_addr[ADDR_W-1 -: 4];

    // region decode: scan downwards so the lowest matching channel wins
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--)
            if (tag == DEV_BASE[4*i +: 4]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
    end

    assign mmio_hit      = (dmem_read_in || dmem_write_in) && hit_any;
    assign mem_stall     = (state_q == IDLE && mmio_hit) || state_q == REQ;
    assign dmem_data_out = (state_q == DONE && !we_q) ? rdata_q : '0;
    assign bus_err       = bus_err_q;
    assign dev_req       = (state_q == REQ) ? (NUM_DEV'(1) << idx_q) : '0;
    assign dev_we        = we_q;
    assign dev_addr      = addr_q;
    assign dev_wdata     = wdata_q;
    assign dev_be        = be_q;
    assign ack           = state_q == REQ && dev_ack[idx_q];
    assign tmo           = state_q == REQ && cnt_q == CW'(TIMEOUT - 1);
    assign push          = ack || tmo;
    assign rdata_d       = ack ? dev_rdata[{idx_q, 5'd0} +: 32] : 32'hDEAD_BEEF;
    assign trace_d       = {~ack, we_q, idx_q, addr_q, we_q ? wdata_q : rdata_d};

    // transaction FSM: latch the access, wait for ack or timeout, hold the result while the core is stalled elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (mmio_hit) begin
                    addr_q  <= dmem_addr;
                    wdata_q <= data_from_reg;
                    be_q    <= dmem_byte_w_en;
                    we_q    <= dmem_write_in;
                    idx_q   <= hit_idx;
                    cnt_q   <= '0;
                    state_q <= REQ;
                end
                REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (push) begin
                        rdata_q   <= rdata_d;
                        bus_err_q <= ~ack;
                        state_q   <= DONE;
                    end
                end
                DONE: if (!ext_stall) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trace_empty = wp_q == rp_q;
    assign trace_full  = (wp_q ^ rp_q) == {1'b1, {(PW-1){1'b0}}};
    assign trace_data  = mem_q[rp_q[PW-2:0]];
    assign trace_ovf   = ovf_q;
    assign do_rd       = trace_rd_en && !trace_empty;
    assign do_wr       = push && (!trace_full || do_rd);

    // trace pointers and saturating count of entries dropped while full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= '0;
        end else begin
            if (do_wr) wp_q <= wp_q + PW'(1);
            if (do_rd) rp_q <= rp_q + PW'(1);
            if (push && !do_wr && ovf_q != 8'hff) ovf_q <= ovf_q + 8'd1;
        end
    end

    // trace storage; contents are only visible through valid pointers so need no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q[PW-2:0]] <= trace_d;
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: randomized scoreboard bench for mmio_bridge against a transaction-level model
module tb_mmio_bridge;
    localparam int AW = 30;
    localparam int DEPTH = 64;
    typedef struct {
        int          idx;
        bit          we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
        bit          err;
        int          stall;
        int          hold;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, dmem_read_in, dmem_write_in, ext_stall, trace_rd_en;
    logic [AW-1:0] dmem_addr, dev_addr;
    logic [31:0]   data_from_reg, dmem_data_out, dev_wdata;
    logic [3:0]    dmem_byte_w_en, dev_req, dev_ack, dev_be;
    logic          mem_stall, mmio_hit, bus_err, dev_we, trace_empty, trace_full;
    logic [127:0]  dev_rdata;
    logic [65:0]   trace_data;
    logic [7:0]    trace_ovf;

    exp_t        sb_q[$];
    logic [65:0] tr_q[$];
    exp_t        rq;
    int          ovf_exp, n_chk, n_pass, plan_idx, plan_ack, rsp_cyc;
    bit          err_exp;
    logic [31:0] plan_rd;
    logic [15:0] tags = 16'hfedc;

    mmio_bridge dut (
        .clk(clk), .rst(rst),
        .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in), .dmem_addr(dmem_addr),
        .data_from_reg(data_from_reg), .dmem_byte_w_en(dmem_byte_w_en), .ext_stall(ext_stall),
        .mem_stall(mem_stall), .dmem_data_out(dmem_data_out), .mmio_hit(mmio_hit), .bus_err(bus_err),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata),
        .trace_rd_en(trace_rd_en), .trace_data(trace_data), .trace_empty(trace_empty),
        .trace_full(trace_full), .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: got 1 expected 0", nm);
    endtask

    // device model: acks the selected channel after the planned number of request cycles, noise on the others
    initial begin
        dev_ack = '0;
        dev_rdata = '0;
        rsp_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_cyc = (rst && dev_req[plan_idx]) ? rsp_cyc + 1 : 0;
            for (int i = 0; i < 4; i++) begin
                dev_rdata[32*i +: 32] = $urandom;
                dev_ack[i] = (i == plan_idx) ? (rsp_cyc != 0 && rsp_cyc == plan_ack) : 1'($urandom_range(0, 1));
            end
            if (rsp_cyc != 0 && rsp_cyc == plan_ack) dev_rdata[32*plan_idx +: 32] = plan_rd;
        end
    end

    // monitor: pops the scoreboard when a result is presented and keeps the trace model in step
    initial begin
        exp_t cur;
        int stall_n, done_n;
        bit in_done, done_now;
        stall_n = 0;
        done_n = 0;
        in_done = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_n = 0;
                done_n = 0;
                in_done = 0;
            end else begin
                done_now = mmio_hit && !mem_stall;
                if (in_done && !done_now) begin
                    chk("done_cycles", done_n, cur.hold + 1);
                    void'(sb_q.pop_front());
                    in_done = 0;
                end
                if (done_now && !in_done) begin
                    if (sb_q.size() == 0) fail("unexpected_done");
                    else begin
                        cur = sb_q[0];
                        chk("stall_cycles", stall_n, cur.stall);
                        err_exp = cur.err;
                        if (tr_q.size() < DEPTH) tr_q.push_back({cur.err, cur.we, 2'(cur.idx), cur.addr, cur.we ? cur.wdata : cur.data});
                        else if (ovf_exp < 255) ovf_exp++;
                        in_done = 1;
                        done_n = 0;
                    end
                    stall_n = 0;
                end
                if (in_done) begin
                    done_n++;
                    chk("data_out_done", dmem_data_out, cur.we ? 32'd0 : cur.data);
                    chk("dev_req_done", dev_req, 0);
                end else chk("data_out_idle", dmem_data_out, 0);
                if (mem_stall) begin
                    stall_n++;
                    if (sb_q.size() == 0) fail("unexpected_stall");
                    else if (dev_req != 0) begin
                        chk("dev_req", dev_req, 4'b1 << sb_q[0].idx);
                        chk("dev_we", dev_we, sb_q[0].we);
                        chk("dev_addr", dev_addr, sb_q[0].addr);
                        chk("dev_wdata", dev_wdata, sb_q[0].wdata);
                        chk("dev_be", dev_be, sb_q[0].be);
                    end
                end else if (!in_done) stall_n = 0;
                chk("bus_err", bus_err, err_exp);
                chk("trace_empty", trace_empty, tr_q.size() == 0);
                chk("trace_full", trace_full, tr_q.size() == DEPTH);
                chk("trace_ovf", trace_ovf, ovf_exp);
                if (trace_rd_en && tr_q.size() > 0) begin
                    chk("trace_data", trace_data, tr_q[0]);
                    void'(tr_q.pop_front());
                end
            end
        end
    end

    task automatic txn(input int idx, input bit we, input int ack_at, input int hold, input bit rd_sim, input logic [31:0] rd);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        e.idx = idx;
        e.we = we;
        e.addr = {tags[4*idx +: 4], 26'($urandom)};
        e.wdata = $urandom;
        e.be = 4'($urandom);
        e.err = ack_at == 0 || ack_at > 255;
        e.data = e.err ? 32'hDEADBEEF : rd;
        e.stall = 1 + (e.err ? 255 : ack_at);
        e.hold = hold;
        sb_q.push_back(e);
        plan_idx = idx;
        plan_ack = ack_at;
        plan_rd = rd;
        dmem_read_in = !we;
        dmem_write_in = we;
        dmem_addr = e.addr;
        data_from_reg = e.wdata;
        dmem_byte_w_en = e.be;
        for (n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            trace_rd_en = rd_sim && n == ack_at;
            if (!mem_stall) break;
        end
        if (n > 300) fail("txn_timeout");
        for (int k = 0; k < hold; k++) begin
            ext_stall = 1;
            @(posedge clk);
            #1;
        end
        ext_stall = 0;
        @(posedge clk);
        #1;
        dmem_read_in = 0;
        dmem_write_in = 0;
        trace_rd_en = 0;
    endtask

    task automatic rtxn(input int ack_at, input int hold, input bit rd_sim);
        txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), ack_at, hold, rd_sim, $urandom);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            trace_rd_en = 1;
        end
        @(posedge clk);
        #1;
        trace_rd_en = 0;
    endtask

    function automatic int rnd_ack();
        int r;
        r = $urandom_range(0, 19);
        return r == 0 ? 0 : r == 1 ? 255 : int'($urandom_range(1, 6));
    endfunction

    // stimulus: directed corner cases, random traffic, FIFO overflow and reset during a request
    initial begin
        rst = 0;
        dmem_read_in = 0;
        dmem_write_in = 0;
        dmem_addr = '0;
        data_from_reg = '0;
        dmem_byte_w_en = '0;
        ext_stall = 0;
        trace_rd_en = 0;
        plan_idx = 0;
        plan_ack = 0;
        plan_rd = '0;
        err_exp = 0;
        ovf_exp = 0;
        n_chk = 0;
        n_pass = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dev_req", dev_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_data_out", dmem_data_out, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_empty", trace_empty, 1);
        chk("rst_full", trace_full, 0);
        chk("rst_ovf", trace_ovf, 0);
        rst = 1;
        @(posedge clk);
        #1;
        dmem_read_in = 1;
        dmem_addr = {4'h0, 26'($urandom)};
        #1;
        chk("nohit_hit", mmio_hit, 0);
        chk("nohit_stall", mem_stall, 0);
        @(posedge clk);
        #1;
        chk("nohit_dev_req", dev_req, 0);
        chk("nohit_stall2", mem_stall, 0);
        dmem_read_in = 0;
        txn(1, 0, 3, 0, 0, 32'h12345678);
        drain(2);
        txn(0, 1, 0, 0, 0, $urandom);
        txn(2, 0, 1, 0, 0, $urandom);
        txn(3, 0, 255, 0, 0, $urandom);
        txn(1, 1, 2, 3, 0, $urandom);
        drain(4);
        repeat (40) begin
            rtxn(rnd_ack(), $urandom_range(0, 2), 0);
            if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 4));
        end
        drain(tr_q.size() + 2);
        repeat (65) rtxn(1, 0, 0);
        rtxn(1, 0, 1);
        repeat (260) rtxn(1, 0, 0);
        drain(10);
        txn(0, 1, 0, 0, 0, $urandom);
        @(posedge clk);
        #1;
        rq.idx = 3;
        rq.we = 0;
        rq.addr = {tags[15:12], 26'($urandom)};
        rq.wdata = $urandom;
        rq.be = 4'hf;
        rq.data = '0;
        rq.err = 0;
        rq.stall = 0;
        rq.hold = 0;
        sb_q.push_back(rq);
        plan_idx = 3;
        plan_ack = 0;
        dmem_read_in = 1;
        dmem_addr = rq.addr;
        data_from_reg = rq.wdata;
        dmem_byte_w_en = rq.be;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_dev_req", dev_req, 4'b1000);
        #1 rst = 0;
        #1;
        chk("arst_dev_req", dev_req, 0);
        chk("arst_empty", trace_empty, 1);
        chk("arst_full", trace_full, 0);
        chk("arst_ovf", trace_ovf, 0);
        chk("arst_bus_err", bus_err, 0);
        dmem_read_in = 0;
        #1;
        chk("arst_stall", mem_stall, 0);
        sb_q.delete();
        tr_q.delete();
        ovf_exp = 0;
        err_exp = 0;
        @(posedge clk);
        #1 rst = 1;
        txn(2, 0, 2, 0, 0, $urandom);
        drain(2);
        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
